// File: rtl/crack_sched.sv
// crack_sched: hands keys 0..KEY_MAX to two cracker cores, round-robin, one dispatch per cycle, registered outputs.
// A core takes a key only when it is ready and not busy. CRACK_SCHED_LOWEST_KEY_EN reports the lowest hit key, not the first.
module crack_sched #(
  parameter logic [23:0] KEY_MAX = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic        done,
  output logic        key_found,
  output logic [23:0] key,
  input  logic        c0_rdy,
  input  logic        c1_rdy,
  output logic        c0_en,
  output logic        c1_en,
  output logic [23:0] c0_key,
  output logic [23:0] c1_key,
  input  logic        c0_done,
  input  logic        c1_done,
  input  logic        c0_hit,
  input  logic        c1_hit
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [24:0] next_key_q, next_key_d;
  logic        busy0_q, busy0_d;
  logic        busy1_q, busy1_d;
  logic        prio_q, prio_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [23:0] key_q, key_d;
  logic        c0_en_q, c0_en_d;
  logic        c1_en_q, c1_en_d;
  logic [23:0] c0_key_q, c0_key_d;
  logic [23:0] c1_key_q, c1_key_d;

  logic        hit0, hit1, can_dispatch, elig0, elig1, grant0, grant1;

  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    busy0_d      = busy0_q;
    busy1_d      = busy1_q;
    prio_d       = prio_q;
    done_d       = done_q;
    found_d      = found_q;
    key_d        = key_q;
    c0_en_d      = 1'b0;
    c1_en_d      = 1'b0;
    c0_key_d     = c0_key_q;
    c1_key_d     = c1_key_q;
    hit0         = c0_done && c0_hit;
    hit1         = c1_done && c1_hit;
    can_dispatch = 1'b0;
    elig0        = 1'b0;
    elig1        = 1'b0;
    grant0       = 1'b0;
    grant1       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d    = DISPATCH;
          next_key_d = '0;
          busy0_d    = 1'b0;
          busy1_d    = 1'b0;
          prio_d     = 1'b0;
          done_d     = 1'b0;
          found_d    = 1'b0;
          key_d      = '0;
        end
      end
      DISPATCH, DRAIN: begin
        if (c0_done) busy0_d = 1'b0;
        if (c1_done) busy1_d = 1'b0;

`ifdef CRACK_SCHED_LOWEST_KEY_EN
        if (hit0 && (!found_d || c0_key_q < key_d)) begin
          found_d = 1'b1;
          key_d   = c0_key_q;
        end
        if (hit1 && (!found_d || c1_key_q < key_d)) begin
          found_d = 1'b1;
          key_d   = c1_key_q;
        end
`else
        // First hit wins; core 0 takes a same-cycle tie.
        if (!found_q) begin
          if (hit0) begin
            found_d = 1'b1;
            key_d   = c0_key_q;
          end else if (hit1) begin
            found_d = 1'b1;
            key_d   = c1_key_q;
          end
        end
`endif

        if (state_q == DISPATCH) begin
          // A hit seen this cycle already blocks the dispatch decided in it.
          can_dispatch = !found_q && !hit0 && !hit1 && (next_key_q <= {1'b0, KEY_MAX});
          elig0        = c0_rdy && !busy0_q;
          elig1        = c1_rdy && !busy1_q;
          grant0       = can_dispatch && elig0 && (!elig1 || !prio_q);
          grant1       = can_dispatch && elig1 && !grant0;
          if (grant0) begin
            c0_en_d    = 1'b1;
            c0_key_d   = next_key_q[23:0];
            busy0_d    = 1'b1;
            prio_d     = 1'b1;
            next_key_d = next_key_q + 25'd1;
          end
          if (grant1) begin
            c1_en_d    = 1'b1;
            c1_key_d   = next_key_q[23:0];
            busy1_d    = 1'b1;
            prio_d     = 1'b0;
            next_key_d = next_key_q + 25'd1;
          end
          if (found_d || (next_key_d > {1'b0, KEY_MAX})) state_d = DRAIN;
        end else if (!busy0_d && !busy1_d) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      next_key_q <= '0;
      busy0_q    <= 1'b0;
      busy1_q    <= 1'b0;
      prio_q     <= 1'b0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      key_q      <= '0;
      c0_en_q    <= 1'b0;
      c1_en_q    <= 1'b0;
      c0_key_q   <= '0;
      c1_key_q   <= '0;
    end else begin
      state_q    <= state_d;
      next_key_q <= next_key_d;
      busy0_q    <= busy0_d;
      busy1_q    <= busy1_d;
      prio_q     <= prio_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      key_q      <= key_d;
      c0_en_q    <= c0_en_d;
      c1_en_q    <= c1_en_d;
      c0_key_q   <= c0_key_d;
      c1_key_q   <= c1_key_d;
    end
  end

  assign rdy       = rdy_q;
  assign done      = done_q;
  assign key_found = found_q;
  assign key       = key_q;
  assign c0_en     = c0_en_q;
  assign c1_en     = c1_en_q;
  assign c0_key    = c0_key_q;
  assign c1_key    = c1_key_q;

endmodule

// File: tb/tb_crack_sched.sv
// Bench for crack_sched: behavioural core models plus a scoreboard of dispatch order and expected search result.
module tb_crack_sched;
  localparam int KM = 15;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        rdy, done, key_found;
  logic [23:0] key;
  logic        c0_rdy, c1_rdy, c0_en, c1_en, c0_done, c1_done, c0_hit, c1_hit;
  logic [23:0] c0_key, c1_key;

  always #5 clk = ~clk;

  crack_sched #(.KEY_MAX(24'd15)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .done(done), .key_found(key_found), .key(key),
    .c0_rdy(c0_rdy), .c1_rdy(c1_rdy), .c0_en(c0_en), .c1_en(c1_en),
    .c0_key(c0_key), .c1_key(c1_key), .c0_done(c0_done), .c1_done(c1_done),
    .c0_hit(c0_hit), .c1_hit(c1_hit)
  );

  // Core models: auto mode finishes after lat_m cycles, manual mode waits for the script.
  bit          auto_m = 1'b1;
  bit          sticky_m = 1'b0;
  int          lat_m = 5;
  bit          hitmap [0:KM];
  logic [1:0]  busy_m = '0, a_done = '0, a_hit = '0, m_done = '0, m_hit = '0, rdy_m = 2'b11;
  logic [23:0] key_m [2];
  int          cnt_m [2];
  int          since_m [2];

  assign c0_rdy  = rdy_m[0];
  assign c1_rdy  = rdy_m[1];
  assign c0_done = auto_m ? a_done[0] : m_done[0];
  assign c1_done = auto_m ? a_done[1] : m_done[1];
  assign c0_hit  = auto_m ? a_hit[0] : m_hit[0];
  assign c1_hit  = auto_m ? a_hit[1] : m_hit[1];

  // Scoreboard
  int  n_vec = 0, n_bad = 0;
  bit  active = 1'b0, done_seen = 1'b0, exp_found = 1'b0;
  int  exp_key = 0, exp_next = 0, n_disp = 0, hit_cyc = -1, cyc = 0, max_key = -1;
  int  d_key [0:63];
  int  d_core [0:63];
  logic        e, dn, ht;
  logic [23:0] k;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_m = '0; a_done = '0; a_hit = '0; rdy_m = 2'b11;
      active = 1'b0; done_seen = 1'b0; exp_found = 1'b0; exp_key = 0;
    end else begin
      cyc++;
      chk("dual_en", c0_en & c1_en, 0);
      for (int c = 0; c < 2; c++) begin
        e = c ? c1_en : c0_en;
        k = c ? c1_key : c0_key;
        if (busy_m[c]) chk("key_stable", k, key_m[c]);
        if (e) begin
          chk("en_while_busy", busy_m[c], 0);
          chk("en_while_idle", !active, 0);
          chk("en_after_hit", (hit_cyc >= 0) && (cyc > hit_cyc), 0);
          chk("disp_key", k, exp_next);
          chk("disp_range", int'(k) > KM, 0);
          if (n_disp < 64) begin
            d_key[n_disp]  = int'(k);
            d_core[n_disp] = c;
          end
          n_disp++;
          exp_next++;
          if (int'(k) > max_key) max_key = int'(k);
        end
      end

      if (active && done) begin
        chk("res_found", key_found, exp_found);
        chk("res_key", key, exp_key);
        chk("rdy_at_done", rdy, 1);
        chk("drained", busy_m, 0);
        active = 1'b0;
        done_seen = 1'b1;
      end else if (active) begin
        chk("rdy_busy", rdy, 0);
      end else begin
        chk("rdy_idle", rdy, 1);
        chk("done_hold", done, done_seen);
        chk("found_hold", key_found, exp_found);
        chk("key_hold", key, exp_key);
      end

      for (int c = 0; c < 2; c++) begin
        e = c ? c1_en : c0_en;
        k = c ? c1_key : c0_key;
        if (a_done[c]) begin
          a_done[c] = 1'b0;
          a_hit[c]  = 1'b0;
        end
        if (e) begin
          busy_m[c] = 1'b1; key_m[c] = k; cnt_m[c] = lat_m; since_m[c] = 0;
        end else if (busy_m[c]) begin
          since_m[c]++;
          if (auto_m) begin
            cnt_m[c]--;
            if (cnt_m[c] == 0) begin
              a_done[c] = 1'b1;
              a_hit[c]  = (int'(key_m[c]) <= KM) && hitmap[key_m[c][3:0]];
              busy_m[c] = 1'b0;
            end
          end else if (m_done[c]) begin
            busy_m[c] = 1'b0;
          end
        end
        rdy_m[c] = !busy_m[c] || (sticky_m && since_m[c] < 3);
      end

      // Hits as the scheduler will sample them at the coming edge.
      for (int c = 0; c < 2; c++) begin
        dn = auto_m ? a_done[c] : m_done[c];
        ht = auto_m ? a_hit[c] : m_hit[c];
        if (active && dn && ht) begin
`ifdef CRACK_SCHED_LOWEST_KEY_EN
          if (!exp_found || int'(key_m[c]) < exp_key) exp_key = int'(key_m[c]);
          exp_found = 1'b1;
`else
          if (!exp_found) begin
            exp_found = 1'b1;
            exp_key   = int'(key_m[c]);
          end
`endif
          if (hit_cyc < 0) hit_cyc = cyc;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic start();
    poke();
    active = 1'b1; done_seen = 1'b0; exp_found = 1'b0; exp_key = 0;
    exp_next = 0; n_disp = 0; hit_cyc = -1; max_key = -1;
  endtask

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    while (active && i < lim) begin
      @(posedge clk);
      i++;
    end
    chk("done_timeout", active, 0);
    active = 1'b0;
    cycles(1);
  endtask

  task automatic rel(input logic [1:0] mask, input logic [1:0] hits);
    @(posedge clk); #1 m_done = mask; m_hit = hits;
    @(posedge clk); #1 m_done = '0;   m_hit = '0;
    cycles(3);
  endtask

  initial begin
    int i;
    rst = 1'b1;
    en  = 1'b0;
    for (int j = 0; j <= KM; j++) hitmap[j] = 1'b0;
    cycles(2);
    chk("rst_rdy", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_found", key_found, 0);
    chk("rst_key", key, 0);
    chk("rst_c0_en", c0_en, 0);
    chk("rst_c1_en", c1_en, 0);
    rst = 1'b0;
    cycles(2);

    // Only key 7 hits.
    hitmap[7] = 1'b1;
    start();
    wait_done(400);
    chk("hit7_found", key_found, 1);
    chk("hit7_key", key, 7);
    chk("ord0_core", d_core[0], 0); chk("ord0_key", d_key[0], 0);
    chk("ord1_core", d_core[1], 1); chk("ord1_key", d_key[1], 1);
    chk("ord2_core", d_core[2], 0); chk("ord2_key", d_key[2], 2);
    chk("ord3_core", d_core[3], 1); chk("ord3_key", d_key[3], 3);
    chk("max_key_le9", max_key > 9, 0);
    hitmap[7] = 1'b0;

    // Exhaustion, then a rescan.
    start();
    wait_done(600);
    chk("exh_count", n_disp, 16);
    chk("exh_found", key_found, 0);
    chk("exh_key", key, 0);
    start();
    wait_done(600);
    chk("rescan_count", n_disp, 16);
    chk("rescan_first", d_key[0], 0);
    chk("rescan_last", d_key[15], 15);

    // Cores keep rdy high after en; stray en pulses mid-search.
    sticky_m = 1'b1;
    start();
    cycles(10);
    poke();
    cycles(7);
    poke();
    wait_done(600);
    chk("sticky_count", n_disp, 16);
    sticky_m = 1'b0;

    // Same-cycle hits: c0 on key 9, c1 on key 8.
    auto_m = 1'b0;
    start();
    cycles(3);
    chk("man_c0_first", d_core[0], 0);
    chk("man_c1_second", d_core[1], 1);
    repeat (6) rel(2'b01, 2'b00);
    rel(2'b10, 2'b00);
    rel(2'b01, 2'b00);
    chk("tie_c0_key", key_m[0], 9);
    chk("tie_c1_key", key_m[1], 8);
    @(posedge clk); #1 m_done = 2'b11; m_hit = 2'b11;
    @(posedge clk); #1 m_done = 2'b00; m_hit = 2'b00;
    wait_done(50);
    chk("tie_found", key_found, 1);
`ifdef CRACK_SCHED_LOWEST_KEY_EN
    chk("tie_key", key, 8);
`else
    chk("tie_key", key, 9);
`endif

    // c1 hits key 4 one cycle before c0 hits key 3.
    start();
    cycles(3);
    rel(2'b10, 2'b00);
    rel(2'b01, 2'b00);
    rel(2'b10, 2'b00);
    chk("seq_c0_key", key_m[0], 3);
    chk("seq_c1_key", key_m[1], 4);
    @(posedge clk); #1 m_done = 2'b10; m_hit = 2'b10;
    @(posedge clk); #1 m_done = 2'b01; m_hit = 2'b01;
    @(posedge clk); #1 m_done = 2'b00; m_hit = 2'b00;
    wait_done(50);
    chk("seq_found", key_found, 1);
`ifdef CRACK_SCHED_LOWEST_KEY_EN
    chk("seq_key", key, 3);
`else
    chk("seq_key", key, 4);
`endif
    auto_m = 1'b1;
    cycles(2);

    // Reset in the middle of dispatching, once key 5 is next.
    start();
    i = 0;
    while (n_disp < 5 && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    chk("reach_key5", n_disp, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_found", key_found, 0);
    chk("mid_rst_key", key, 0);
    chk("mid_rst_c0_en", c0_en, 0);
    chk("mid_rst_c1_en", c1_en, 0);
    chk("mid_rst_c0_key", c0_key, 0);
    chk("mid_rst_c1_key", c1_key, 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    start();
    cycles(3);
    chk("post_rst_key", d_key[0], 0);
    chk("post_rst_core", d_core[0], 0);
    wait_done(600);
    chk("post_rst_count", n_disp, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 Parameter: KEY_MAX, 24'hFFFFFF, last key in the search space (inclusive); benches use small values.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  one-cycle start pulse; honoured only while rdy=1.
REQ-005 Port: rdy  output  1  scheduler idle (IDLE or DONE), accepts en.
REQ-006 Port: done  output  1  search finished; held until next accepted en or reset.
REQ-007 Port: key_found  output  1  a core reported a hit; valid while done=1.
REQ-008 Port: key  output  24  winning key; 0 when key_found=0.
REQ-009 Port: c0_rdy, c1_rdy  input  1 each  cracker core idle.
REQ-010 Port: c0_en, c1_en  output  1 each  one-cycle dispatch pulse to core.
REQ-011 Port: c0_key, c1_key  output  24 each  key under test; stable from the en cycle until that core's done pulse.
REQ-012 Port: c0_done, c1_done  input  1 each  one-cycle result pulse from core.
REQ-013 Port: c0_hit, c1_hit  input  1 each  key decrypted to valid plaintext; sampled only with matching cN_done.

Function
REQ-014 States: IDLE, DISPATCH, DRAIN, DONE.
REQ-015 IDLE/DONE + en -> DISPATCH; clear next_key to 0, key_found to 0, key to 0, done to 0.
REQ-016 DISPATCH: at most one dispatch per cycle, to a core with cN_rdy=1 and busy flag clear, while next_key <= KEY_MAX and no hit recorded.
REQ-017 Dispatch: cN_en=1 for exactly one cycle, cN_key=next_key, busy_N set, next_key increments; next_key does not wrap past KEY_MAX.
REQ-018 Both cores eligible: round-robin, the core not granted last wins; after reset or start, core 0 wins.
REQ-019 Busy flag overrides cN_rdy: no second en to a core until its cN_done is seen, even if cN_rdy stays high.
REQ-020 cN_done clears busy_N; no cN_en to that core in the same cycle as its cN_done.
REQ-021 cN_done with cN_hit records a hit (per REQ-030); dispatching stops from the following cycle.
REQ-022 DISPATCH -> DRAIN when a hit is recorded or the key after KEY_MAX would be issued.
REQ-023 DRAIN: no dispatches; hits from in-flight cores are still evaluated; -> DONE when both busy flags are clear.
REQ-024 DONE: done=1, rdy=1, key/key_found held.
REQ-025 en outside IDLE/DONE is ignored, with no side effects.
REQ-026 Every key in 0..KEY_MAX is dispatched at most once per search, in ascending order.
REQ-027 Exhaustion without a hit: done=1, key_found=0, key=0.

Reset
REQ-028 rst asserted: immediately IDLE, rdy=1, done=0, key_found=0, key=0, c0_en=c1_en=0, c0_key=c1_key=0, busy flags clear, next_key=0, round-robin pointer to core 0.
REQ-029 Reset mid-search abandons in-flight keys; cores are reset by the same rst; the next en restarts from key 0.

Configuration
REQ-030 Macro CRACK_SCHED_LOWEST_KEY_EN defined: across all hits in a search, including DRAIN, report the numerically lowest hit key. Undefined: report the first hit by cycle, with core 0 winning a same-cycle tie; later hits are ignored.

Verification
REQ-031 Reset -> rdy=1, done=0, key_found=0, key=0, c0_en=c1_en=0.
REQ-032 KEY_MAX=15, core models with 5-cycle latency, only key 7 hits -> dispatch order c0:0, c1:1, c0:2, ...; no key >9 dispatched; done with key_found=1, key=7.
REQ-033 KEY_MAX=15, no hits -> exactly 16 dispatches of keys 0..15, each once; done with key_found=0, key=0; second en rescans from key 0.
REQ-034 Same-cycle c0 hit key 9 and c1 hit key 8 -> key=8 with the macro, key=9 without. c1 hit key 4 one cycle before c0 hit key 3 -> key=3 with the macro, key=4 without.
REQ-035 Core model holds cN_rdy=1 for 3 cycles after cN_en -> no second cN_en before cN_done; en pulses during DISPATCH are ignored.
REQ-036 rst pulse mid-DISPATCH at next_key=5 -> all outputs at reset values the same cycle; a following en dispatches key 0 to c0.
